// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration chain loader: FSM state encoding
// and the word-count helpers derived from CHAIN_LEN and WORD_W.
package cfg_loader_pkg;

  localparam int unsigned StateW = 3;

  localparam logic [StateW-1:0] StIdleEnc  = 3'd0;
  localparam logic [StateW-1:0] StLoadEnc  = 3'd1;
  localparam logic [StateW-1:0] StShiftEnc = 3'd2;
  localparam logic [StateW-1:0] StSetEnc   = 3'd3;
  localparam logic [StateW-1:0] StDoneEnc  = 3'd4;

  typedef enum logic [StateW-1:0] {
    StIdle  = StIdleEnc,
    StLoad  = StLoadEnc,
    StShift = StShiftEnc,
    StSet   = StSetEnc,
    StDone  = StDoneEnc
  } state_e;

  // Number of host words needed to cover the whole chain.
  function automatic int unsigned num_words(input int unsigned chain_len,
                                            input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Bits actually shifted from the final word (a full word when it divides evenly).
  function automatic int unsigned last_word_bits(input int unsigned chain_len,
                                                 input int unsigned word_w);
    return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
  endfunction

endpackage

// File: rtl/config_chain_loader_if.sv
// Host bitstream word handshake between the front end and the chain loader.
interface config_chain_loader_if #(
  parameter int unsigned WORD_W = 32
) ();

  logic              word_valid;
  logic              word_ready;
  logic [WORD_W-1:0] word_data;

  modport master (
    output word_valid,
    output word_data,
    input  word_ready
  );

  modport slave (
    input  word_valid,
    input  word_data,
    output word_ready
  );

endinterface

// File: rtl/cfg_piso.sv
// Parallel-load, shift-right register; bit 0 is the serial output and zeros
// are shifted in from the top. clr has priority over load, load over shift.
module cfg_piso #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  output logic              serial_out
);

  logic [WORD_W-1:0] data_q;

  // Serializer register.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= data;
    end else if (shift) begin
      data_q <= data_q >> 1;
    end
  end

  assign serial_out = data_q[0];

endmodule

// File: rtl/config_chain_loader.sv
// Configuration chain loader: takes bitstream words from the host, shifts them
// LSB-first onto the tile config chain, then pulses the commit strobe.
// Optional readback of the returned chain data is enabled by defining
// CFG_LOADER_READBACK_EN.
module config_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned CHAIN_LEN = 1024,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  config_chain_loader_if.slave  word_if,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_cen,
  output logic                  cfg_shift_out,
  input  logic                  cfg_shift_in,
  output logic                  cfg_set,
  output logic                  rb_valid,
  output logic [WORD_W-1:0]     rb_data
);

  localparam int unsigned NumWords = num_words(CHAIN_LEN, WORD_W);
  localparam int unsigned LastBits = last_word_bits(CHAIN_LEN, WORD_W);
  localparam int unsigned WbW      = $clog2(WORD_W + 1);
  localparam int unsigned NwW      = $clog2(NumWords + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [NwW-1:0]   words_left_q, words_left_d;
  logic [WbW-1:0]   word_left_q, word_left_d;

  logic piso_load, piso_shift, piso_clr;

  logic busy_q, done_q, cen_q, set_q, word_ready_q;

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    words_left_d = words_left_q;
    word_left_d  = word_left_q;
    piso_load    = 1'b0;
    piso_shift   = 1'b0;
    piso_clr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StLoad;
          rem_d        = CNT_W'(CHAIN_LEN);
          words_left_d = NwW'(NumWords);
        end
      end
      StLoad: begin
        if (word_if.word_valid) begin
          piso_load    = 1'b1;
          word_left_d  = (words_left_q == NwW'(1)) ? WbW'(LastBits) : WbW'(WORD_W);
          words_left_d = words_left_q - NwW'(1);
          state_d      = StShift;
        end
      end
      StShift: begin
        piso_shift  = 1'b1;
        rem_d       = rem_q - CNT_W'(1);
        word_left_d = word_left_q - WbW'(1);
        if (word_left_q == WbW'(1)) begin
          if (rem_q == CNT_W'(1)) begin
            state_d  = StSet;
            // Drop unused upper bits of a partial last word so the line idles at 0.
            piso_clr = 1'b1;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StSet:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rem_q        <= '0;
      words_left_q <= '0;
      word_left_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cen_q        <= 1'b0;
      set_q        <= 1'b0;
      word_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      words_left_q <= words_left_d;
      word_left_q  <= word_left_d;
      busy_q       <= (state_d != StIdle);
      done_q       <= (state_d == StDone);
      cen_q        <= (state_d == StShift);
      set_q        <= (state_d == StSet);
      word_ready_q <= (state_d == StLoad);
    end
  end

  cfg_piso #(
    .WORD_W (WORD_W)
  ) u_piso (
    .clk        (clk),
    .rst        (rst),
    .clr        (piso_clr),
    .load       (piso_load),
    .shift      (piso_shift),
    .data       (word_if.word_data),
    .serial_out (cfg_shift_out)
  );

  assign word_if.word_ready = word_ready_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign cfg_cen            = cen_q;
  assign cfg_set            = set_q;

`ifdef CFG_LOADER_READBACK_EN
  localparam int unsigned IdxW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] rb_acc_q, rb_acc_d;
  logic [IdxW-1:0]   rb_idx_q;
  logic              rb_valid_q;
  logic [WORD_W-1:0] rb_data_q;

  // Accumulator with the bit returned this shift cycle inserted.
  always_comb begin
    rb_acc_d           = rb_acc_q;
    rb_acc_d[rb_idx_q] = cfg_shift_in;
  end

  // Collect returned bits LSB-first; publish one word per host word shifted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_acc_q   <= '0;
      rb_idx_q   <= '0;
      rb_valid_q <= 1'b0;
      rb_data_q  <= '0;
    end else begin
      rb_valid_q <= 1'b0;
      rb_data_q  <= '0;
      if (piso_load) begin
        rb_acc_q <= '0;
        rb_idx_q <= '0;
      end else if (piso_shift) begin
        rb_acc_q <= rb_acc_d;
        rb_idx_q <= rb_idx_q + IdxW'(1);
        if (word_left_q == WbW'(1)) begin
          rb_valid_q <= 1'b1;
          rb_data_q  <= rb_acc_d;
        end
      end
    end
  end

  assign rb_valid = rb_valid_q;
  assign rb_data  = rb_data_q;
`else
  logic unused_shift_in;
  assign unused_shift_in = cfg_shift_in;
  assign rb_valid        = 1'b0;
  assign rb_data         = '0;
`endif

endmodule

// File: doc/config_chain_loader.md
# config_chain_loader

Host-side driver for the configuration shift chain that runs through every tile's config registers and baked connection-block registers. It accepts bitstream words over a valid/ready handshake and serializes them onto the chain one bit per cycle, gated by the shift-enable. After exactly CHAIN_LEN bits it pulses the chain's set strobe so every tile commits its configuration. It sits between the bitstream source (SPI or Wishbone front end) and the first tile's `shift_in`/`cen`/`set_in`.

## Interface
- `WORD_W`, 32: bitstream word width from the host.
- `CHAIN_LEN`, 1024: total configuration bits in the chain; must be ≥1.
- `CNT_W`, $clog2(CHAIN_LEN+1): bit-counter width.
- `clk`  in  1  fabric clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `word_valid`  in  1  host word available.
- `word_ready`  out  1  loader accepts the word this cycle.
- `word_data`  in  WORD_W  bitstream word, LSB shifted first.
- `busy`  out  1  high from the cycle after `start` until `done`, inclusive.
- `done`  out  1  one-cycle pulse after `cfg_set`.
- `cfg_cen`  out  1  chain shift enable; drives tile `cen`.
- `cfg_shift_out`  out  1  serial data; drives first tile `shift_in`.
- `cfg_shift_in`  in  1  serial data returned from last tile `shift_out`.
- `cfg_set`  out  1  commit strobe; drives tile `set_in`.
- `rb_valid`  out  1  readback word valid (pulse).
- `rb_data`  out  WORD_W  readback word.

## Operation
- FSM states: IDLE, LOAD, SHIFT, SET, DONE.
- IDLE: all outputs 0. `start`=1 → LOAD. `start` in any other state is ignored.
- LOAD: `word_ready`=1. On `word_valid & word_ready`, latch `word_data` into the serializer and set the per-word bit count to min(WORD_W, remaining bits). Next state is SHIFT. With no valid word the FSM waits; `cfg_cen` stays 0, so the chain holds.
- SHIFT: each cycle, `cfg_cen`=1 and `cfg_shift_out`=serializer bit 0. The serializer shifts right and the remaining-bit counter decrements.
  - After the last bit of the word, go to LOAD if remaining > 0, else SET.
  - Last word: words = ceil(CHAIN_LEN/WORD_W). Only the low (CHAIN_LEN mod WORD_W) bits are shifted, or all WORD_W bits when the remainder is 0. Upper bits are ignored.
- SET: `cfg_set`=1 for exactly one cycle, `cfg_cen`=0. Next state is DONE.
- DONE: `done`=1 for one cycle. Next state is IDLE.
- `cfg_cen` is never high in the same cycle as `cfg_set`.
- Reset mid-load: next cycle is IDLE and all outputs are 0. `cfg_set` is never pulsed, so tiles keep their previously committed configuration. The chain contents are don't-care until the next full load.

## Timing
- `start` sampled at cycle t → `busy`=1 and `word_ready`=1 at t+1.
- Word accepted at cycle n → first `cfg_cen` at n+1. Bits follow contiguously, one per cycle.
- One LOAD bubble per word; there is no prefetch.
- Total cycles from `start` to `done`, with `word_valid` always high: 1 + words + CHAIN_LEN + 2.
- All outputs are registered.

## Configuration
- `CFG_LOADER_READBACK_EN` defined:
  - On every `cfg_cen` cycle, `cfg_shift_in` is shifted MSB-ward into a readback register, LSB-first order, so the first returned bit lands in bit 0.
  - `rb_valid` pulses the cycle after the readback register fills with WORD_W bits, or after the last bit of the final partial word. Unused high bits are zero.
  - There is no backpressure.
- Not defined: the readback logic is absent, `rb_valid`/`rb_data` are tied to 0, and `cfg_shift_in` is unused.

## Structure
- Shared package `cfg_loader_pkg`: FSM state encoding localparams, and the words/remainder computation as constant functions of CHAIN_LEN and WORD_W.
- One sub-module, `cfg_piso`: WORD_W-bit parallel-load, shift-right register with load/shift enables and serial output. The readback path reuses it in mirrored form, or inlines it.

## Test plan
- CHAIN_LEN=10, WORD_W=4, words 0xA, 0x5, 0x3, `word_valid` always high, `start` at cycle 0:
  - `cfg_cen` high on cycles 2–5, 7–10, 12–13.
  - Serial bits 0,1,0,1, 1,0,1,0, 1,1.
  - `cfg_set` at cycle 14, `done` at 15, `busy` low at 16.
- Same load, but hold `word_valid` low for 5 cycles before the second word: `cfg_cen` stays 0 during the stall, the bit sequence is unchanged, and `done` arrives 5 cycles later.
- Assert `rst` during the second word's SHIFT: outputs are 0 next cycle, `cfg_set` is never seen, and a following full load completes normally.
- Pulse `start` while `busy`: no effect on the sequence or the cycle count.
- With `CFG_LOADER_READBACK_EN`, chain modeled as a 10-bit shift register preloaded with 0x2B5:
  - `rb_data` sequence is 0x5, 0xB, 0x2.
  - `rb_valid` pulses at cycles 6, 11, 14.
- Without `CFG_LOADER_READBACK_EN`: `rb_valid` is never asserted for any load.
